// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI-Lite slave with NUM_REGS 32-bit registers, byte strobes and a hardware write side-port.
// Latency: B valid the cycle after both AW and W are held; R valid the cycle after the AR handshake.
// Backpressure: one write and one read in flight; AW/W/AR stall until the pending B/R is accepted.
// Build option: define AXI_REGFILE_ERR_RESP_EN to answer decode misses with SLVERR instead of OKAY.
module axi_lite_regfile #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     aw_valid,
   output logic                     aw_ready,
   input  logic [31:0]              aw_addr,
   input  logic [2:0]               aw_prot,
   input  logic                     w_valid,
   output logic                     w_ready,
   input  logic [31:0]              w_data,
   input  logic [3:0]               w_strb,
   output logic                     b_valid,
   input  logic                     b_ready,
   output logic [1:0]               b_resp,
   input  logic                     ar_valid,
   output logic                     ar_ready,
   input  logic [31:0]              ar_addr,
   input  logic [2:0]               ar_prot,
   output logic                     r_valid,
   input  logic                     r_ready,
   output logic [31:0]              r_data,
   output logic [1:0]               r_resp,
   output logic [NUM_REGS*32-1:0]   reg_o,
   output logic [NUM_REGS-1:0]      wr_pulse_o,
   input  logic                     hw_we_i,
   input  logic [7:0]               hw_idx_i,
   input  logic [31:0]              hw_data_i
);
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_REGFILE_ERR_RESP_EN
   localparam logic [1:0] RESP_MISS = 2'b10;
`else
   localparam logic [1:0] RESP_MISS = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e            w_state_q, w_state_d;
   r_state_e            r_state_q, r_state_d;
   logic                aw_have_q, aw_have_d, w_have_q, w_have_d;
   logic [31:0]         aw_addr_q, aw_addr_d, w_data_q, w_data_d;
   logic [3:0]          w_strb_q, w_strb_d;
   logic [1:0]          b_resp_q, b_resp_d, r_resp_q, r_resp_d;
   logic [31:0]         r_data_q, r_data_d;
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [31:0]         regs_q [NUM_REGS];
   logic [31:0]         regs_d [NUM_REGS];

   logic                aw_hs, w_hs, ar_hs, commit;
   logic [31:0]         wr_addr, wr_data, wr_idx, rd_idx;
   logic [3:0]          wr_strb;
   logic                wr_hit, rd_hit;
   logic                unused_prot;

   // Word index relative to BASE_ADDR; the low two address bits drop out in the shift.
   function automatic logic [31:0] dec_idx(input logic [31:0] addr);
      return (addr - BASE_ADDR) >> 2;
   endfunction

   function automatic logic dec_hit(input logic [31:0] addr);
      return (addr >= BASE_ADDR) && (dec_idx(addr) < 32'(NUM_REGS));
   endfunction

   // Readies are forced low while reset is asserted, not just after it.
   assign aw_ready    = rst_n && (w_state_q == W_IDLE) && !aw_have_q;
   assign w_ready     = rst_n && (w_state_q == W_IDLE) && !w_have_q;
   assign ar_ready    = rst_n && (r_state_q == R_IDLE);
   assign b_valid     = (w_state_q == W_RESP);
   assign b_resp      = b_resp_q;
   assign r_valid     = (r_state_q == R_DATA);
   assign r_data      = r_data_q;
   assign r_resp      = r_resp_q;
   assign wr_pulse_o  = wr_pulse_q;
   assign unused_prot = ^{aw_prot, ar_prot};

   assign aw_hs   = aw_valid && aw_ready;
   assign w_hs    = w_valid && w_ready;
   assign ar_hs   = ar_valid && ar_ready;
   // Use the latched half when it arrived earlier, otherwise the live bus value.
   assign wr_addr = aw_have_q ? aw_addr_q : aw_addr;
   assign wr_data = w_have_q ? w_data_q : w_data;
   assign wr_strb = w_have_q ? w_strb_q : w_strb;
   assign wr_idx  = dec_idx(wr_addr);
   assign wr_hit  = dec_hit(wr_addr);
   assign rd_idx  = dec_idx(ar_addr);
   assign rd_hit  = dec_hit(ar_addr);

   // Write FSM: collect AW and W in any order, commit once both are present, hold B until taken.
   always_comb begin
      w_state_d = w_state_q;
      aw_have_d = aw_have_q;
      aw_addr_d = aw_addr_q;
      w_have_d  = w_have_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      b_resp_d  = b_resp_q;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_have_d = 1'b1;
               aw_addr_d = aw_addr;
            end
            if (w_hs) begin
               w_have_d = 1'b1;
               w_data_d = w_data;
               w_strb_d = w_strb;
            end
            if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
               b_resp_d  = wr_hit ? RESP_OKAY : RESP_MISS;
            end
         end
         W_RESP: begin
            if (b_ready) begin
               w_state_d = W_IDLE;
               aw_have_d = 1'b0;
               w_have_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Register next values: hardware word write first, then AXI strobed bytes override it.
   always_comb begin
      wr_pulse_d = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         if (hw_we_i && (hw_idx_i == 8'(k)))
            regs_d[k] = hw_data_i;
         if (commit && wr_hit && (wr_idx == 32'(k))) begin
            wr_pulse_d[k] = 1'b1;
            for (int b = 0; b < 4; b++)
               if (wr_strb[b])
                  regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   // Read FSM: capture the pre-edge register value on AR, hold R until taken.
   always_comb begin
      r_state_d = r_state_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               r_resp_d  = rd_hit ? RESP_OKAY : RESP_MISS;
               r_data_d  = '0;
               for (int k = 0; k < NUM_REGS; k++)
                  if (rd_hit && (rd_idx == 32'(k)))
                     r_data_d = regs_q[k];
            end
         end
         R_DATA: begin
            if (r_ready)
               r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Flatten the register array onto reg_o.
   always_comb begin
      reg_o = '0;
      for (int k = 0; k < NUM_REGS; k++)
         reg_o[32*k +: 32] = regs_q[k];
   end

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_have_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_have_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         b_resp_q   <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         wr_pulse_q <= '0;
         for (int k = 0; k < NUM_REGS; k++)
            regs_q[k] <= RESET_VAL;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_have_q  <= aw_have_d;
         aw_addr_q  <= aw_addr_d;
         w_have_q   <= w_have_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         b_resp_q   <= b_resp_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         wr_pulse_q <= wr_pulse_d;
         for (int k = 0; k < NUM_REGS; k++)
            regs_q[k] <= regs_d[k];
      end
   end
endmodule
